display_scan: RTL and testbench

- Upstream feeder for the seven-segment decoder (4-bit digit in, active-low 8-bit segment code out).
- Time-multiplexes a 4-digit BCD value onto the board's shared-segment display and drives the active-low anodes.
- Presents one nibble per scan slot on `digit`; the decoder turns it into segments.
- Adds frame-synchronous value latching (no tearing), leading-zero blanking, per-digit decimal points and a global enable.
- Sits between the Cat-Mouse score/timer logic and the decoder.

---
 rtl/display_scan.sv | 85 ++++++++
 tb/tb_display_scan.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner: latches a BCD value once per frame and presents one
// nibble, its active-low anode and decimal point per slot to the seven-segment decoder.
module display_scan #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic [3:0]  dp_mask,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic             load_pending_q, load_pending_d;
  logic             tick, load;
  logic [3:0]       an_d, digit_d;
  logic             dp_d;
  logic             lz_zero, slot_blank;

  always_comb begin
    tick           = enable && (count_q == CntMax);
    load           = enable && (load_pending_q || (tick && (idx_q == 2'd3)));
    count_d        = '0;
    idx_d          = '0;
    load_pending_d = 1'b1;
    if (enable) begin
      count_d        = tick ? '0 : count_q + CNT_W'(1);
      idx_d          = tick ? idx_q + 2'd1 : idx_q;
      load_pending_d = load ? 1'b0 : load_pending_q;
    end
    shadow_d = load ? value : shadow_q;
  end

  // Outputs are derived from next-state idx/shadow so they move on the same edge.
  always_comb begin
    unique case (idx_d)
      2'd0:    lz_zero = 1'b0;
      2'd1:    lz_zero = (shadow_d[15:4] == 12'h000);
      2'd2:    lz_zero = (shadow_d[15:8] == 8'h00);
      default: lz_zero = (shadow_d[15:12] == 4'h0);
    endcase
    slot_blank = blank_lz && lz_zero;
    an_d       = 4'b1111;
    digit_d    = 4'hF;
    dp_d       = 1'b1;
    if (enable && !slot_blank) begin
      an_d    = ~(4'b0001 << idx_d);
      digit_d = shadow_d[{idx_d, 2'b00} +: 4];
      dp_d    = ~dp_mask[idx_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q        <= '0;
      idx_q          <= '0;
      shadow_q       <= 16'h0000;
      load_pending_q <= 1'b1;
      an             <= 4'b1111;
      digit          <= 4'hF;
      dp             <= 1'b1;
      frame_start    <= 1'b0;
    end else begin
      count_q        <= count_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      load_pending_q <= load_pending_d;
      an             <= an_d;
      digit          <= digit_d;
      dp             <= dp_d;
      frame_start    <= load;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// Randomised self-checking bench for display_scan; two instances (REFRESH_DIV 4 and 1) share
// stimulus and are compared against a frame-arithmetic reference model.
module tb_display_scan;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  digit_w[2];
  logic [3:0]  an_w[2];
  logic        dp_w[2];
  logic        fs_w[2];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int          div[2] = '{4, 1};
  int          n_edge[2];
  logic [15:0] sh_m[2];
  logic [3:0]  exp_an[2];
  logic [3:0]  exp_digit[2];
  logic        exp_dp[2];
  logic        exp_fs[2];

  display_scan #(.REFRESH_DIV(4), .CNT_W(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .digit(digit_w[0]), .an(an_w[0]), .dp(dp_w[0]), .frame_start(fs_w[0])
  );

  display_scan #(.REFRESH_DIV(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .value(value), .blank_lz(blank_lz),
    .dp_mask(dp_mask), .digit(digit_w[1]), .an(an_w[1]), .dp(dp_w[1]), .frame_start(fs_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_dark(input int k);
    exp_an[k]    = 4'b1111;
    exp_digit[k] = 4'hF;
    exp_dp[k]    = 1'b1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n_edge[k] = 0;
      sh_m[k]   = 16'h0000;
      exp_fs[k] = 1'b0;
      model_dark(k);
    end
  endtask

  // n_edge counts enabled edges since the scan last restarted; slot and frame follow from it.
  task automatic model_step();
    int  slot;
    bit  ld;
    for (int k = 0; k < 2; k++) begin
      if (!enable) begin
        n_edge[k] = 0;
        exp_fs[k] = 1'b0;
        model_dark(k);
      end else begin
        ld = (n_edge[k] == 0) || (((n_edge[k] + 1) % (4 * div[k])) == 0);
        if (ld) sh_m[k] = value;
        exp_fs[k] = ld;
        slot = ((n_edge[k] + 1) / div[k]) % 4;
        if (blank_lz && slot != 0 && (sh_m[k] >> (4 * slot)) == 16'h0000) begin
          model_dark(k);
        end else begin
          exp_an[k]    = 4'b1111 ^ (4'b0001 << slot);
          exp_digit[k] = sh_m[k][4*slot +: 4];
          exp_dp[k]    = ~dp_mask[slot];
        end
        n_edge[k]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s.an%0d", tag, k), {12'h0, an_w[k]}, {12'h0, exp_an[k]});
      check($sformatf("%s.digit%0d", tag, k), {12'h0, digit_w[k]}, {12'h0, exp_digit[k]});
      check($sformatf("%s.dp%0d", tag, k), {15'h0, dp_w[k]}, {15'h0, exp_dp[k]});
      check($sformatf("%s.fs%0d", tag, k), {15'h0, fs_w[k]}, {15'h0, exp_fs[k]});
    end
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all(tag);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b1;
    value    = 16'h1234;
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run("basic", 40);
    value = 16'h5678;
    run("midframe", 24);
    blank_lz = 1'b1;
    value    = 16'h0070;
    run("lz0070", 24);
    value = 16'h0000;
    run("lz0000", 24);
    value = 16'h0105;
    run("lz0105", 24);
    blank_lz = 1'b0;
    dp_mask  = 4'b0100;
    value    = 16'h1234;
    run("dp", 24);
    value = 16'h9999;
    run("pre_dis", 9);
    enable = 1'b0;
    run("disabled", 10);
    enable = 1'b1;
    run("reenable", 24);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) value = 16'($urandom) & {{4{1'($urandom)}}, {4{1'($urandom)}},
                                                            {4{1'($urandom)}}, 4'hF};
      if ($urandom_range(15) == 0) blank_lz = 1'($urandom);
      if ($urandom_range(15) == 0) dp_mask = 4'($urandom);
      enable = ($urandom_range(29) != 0);
      run("rand", 1);
    end

    // Asynchronous reset between clock edges.
    enable = 1'b1;
    run("pre_rst", 6);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
    run("post_rst", 24);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
